// File: rtl/jpeg_mcu_code_sequencer_if.sv
// Stream bundle for the JPEG MCU code sequencer: per-channel code inputs,
// the merged ready/valid code output and the image-level control/status.
interface jpeg_mcu_code_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int CODE_W = 16,
  parameter int LEN_W  = 4
);
  logic                     start;
  logic                     mode;
  logic [15:0]              num_mcu;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*CODE_W-1:0] in_code;
  logic [NUM_CH*LEN_W-1:0]  in_len;
  logic [NUM_CH-1:0]        in_eob;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [CODE_W-1:0]        out_code;
  logic [LEN_W-1:0]         out_len;
  logic [1:0]               out_ch;
  logic                     out_eob;
  logic                     busy;
  logic                     img_done;

  modport master (
    output start, mode, num_mcu, in_valid, in_code, in_len, in_eob, out_ready,
    input  in_ready, out_valid, out_code, out_len, out_ch, out_eob, busy, img_done
  );

  modport slave (
    input  start, mode, num_mcu, in_valid, in_code, in_len, in_eob, out_ready,
    output in_ready, out_valid, out_code, out_len, out_ch, out_eob, busy, img_done
  );
endinterface

// File: rtl/jpeg_mcu_code_sequencer.sv
// Buffers Huffman codes per colour component and replays them on one stream
// in JPEG block order, either MCU-interleaved or component-sequential.
module jpeg_mcu_code_sequencer #(
  parameter int NUM_CH        = 3,
  parameter int CODE_W        = 16,
  parameter int LEN_W         = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int Y_BLK_PER_MCU = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  jpeg_mcu_code_sequencer_if.slave  bus
);
  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam int             ENT_W      = CODE_W + LEN_W + 1;
  localparam int             LAST_BLK_I = Y_BLK_PER_MCU + NUM_CH - 2;
  localparam int             LAST_CH_I  = NUM_CH - 1;
  localparam logic [AW:0]    DEPTH_C    = FIFO_DEPTH[AW:0];
  localparam logic [2:0]     LAST_BLK   = LAST_BLK_I[2:0];
  localparam logic [2:0]     Y_BLK      = Y_BLK_PER_MCU[2:0];
  localparam logic [1:0]     LAST_CH    = LAST_CH_I[1:0];
  localparam logic [17:0]    Y_BLK_18   = 18'(Y_BLK_PER_MCU);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  // Entry layout: {code, len, eob}
  logic [ENT_W-1:0] r_mem [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]    r_wp  [NUM_CH];
  logic [AW-1:0]    r_rp  [NUM_CH];
  logic [AW:0]      r_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_push, w_pop, w_full, w_empty;

  logic        r_mode;
  logic [15:0] r_num_mcu, r_mcu_cnt;
  logic [2:0]  r_blk_idx;
  logic [1:0]  r_seq_ch;
  logic [17:0] r_seq_cnt;

  logic [1:0]       w_cur_ch;
  logic             w_head_vld;
  logic [ENT_W-1:0] w_head;
  logic             w_out_valid, w_deq, w_blk_end, w_mcu_end, w_seq_end, w_final, w_clr;
  logic             w_busy, w_img_done;
  logic [17:0]      w_seq_lim;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]  = (r_cnt[c] == DEPTH_C);
      w_empty[c] = (r_cnt[c] == '0);
      w_push[c]  = bus.in_valid[c] && !w_full[c];
      w_pop[c]   = w_deq && (w_cur_ch == 2'(c));
    end
  end

  // Interleaved order derives the channel from the block slot; sequential keeps its own.
  always_comb begin
    if (r_mode)
      w_cur_ch = (r_blk_idx < Y_BLK) ? 2'd0 : 2'(r_blk_idx - Y_BLK + 3'd1);
    else
      w_cur_ch = r_seq_ch;
    w_head_vld = 1'b0;
    w_head     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_cur_ch == 2'(c)) begin
        w_head_vld = !w_empty[c];
        w_head     = r_mem[c][r_rp[c]];
      end
    end
  end

  assign w_blk_end = w_deq && w_head[0];
  assign w_mcu_end = (r_blk_idx == LAST_BLK);
  assign w_seq_lim = (r_seq_ch == 2'd0) ? ({2'b00, r_num_mcu} * Y_BLK_18) : {2'b00, r_num_mcu};
  assign w_seq_end = (r_seq_cnt == w_seq_lim - 18'd1);
  assign w_final   = w_blk_end &&
                     (r_mode ? (w_mcu_end && (r_mcu_cnt == r_num_mcu - 16'd1))
                             : (w_seq_end && (r_seq_ch == LAST_CH)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_deq       = 1'b0;
    w_clr       = 1'b0;
    w_img_done  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_clr       = 1'b1;
          w_state_nxt = (bus.num_mcu != 16'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_out_valid = w_head_vld;
        w_deq       = w_head_vld && bus.out_ready;
        if (w_final) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_img_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= 1'b0;
      r_num_mcu <= '0;
      r_mcu_cnt <= '0;
      r_blk_idx <= '0;
      r_seq_ch  <= '0;
      r_seq_cnt <= '0;
    end else if (w_clr) begin
      r_mode    <= bus.mode;
      r_num_mcu <= bus.num_mcu;
      r_mcu_cnt <= '0;
      r_blk_idx <= '0;
      r_seq_ch  <= '0;
      r_seq_cnt <= '0;
    end else if (w_blk_end) begin
      if (r_mode) begin
        if (w_mcu_end) begin
          r_blk_idx <= '0;
          r_mcu_cnt <= r_mcu_cnt + 16'd1;
        end else begin
          r_blk_idx <= r_blk_idx + 3'd1;
        end
      end else if (w_seq_end) begin
        r_seq_cnt <= '0;
        r_seq_ch  <= r_seq_ch + 2'd1;
      end else begin
        r_seq_cnt <= r_seq_cnt + 18'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wp[c] <= r_wp[c] + 1'b1;
        if (w_pop[c])  r_rp[c] <= r_rp[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
          2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c])
        r_mem[c][r_wp[c]] <= {bus.in_code[c*CODE_W +: CODE_W], bus.in_len[c*LEN_W +: LEN_W], bus.in_eob[c]};
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = w_out_valid;
  assign bus.out_code  = w_out_valid ? w_head[ENT_W-1 -: CODE_W] : '0;
  assign bus.out_len   = w_out_valid ? w_head[LEN_W:1] : '0;
  assign bus.out_ch    = w_out_valid ? w_cur_ch : 2'd0;
  assign bus.out_eob   = w_out_valid ? w_head[0] : 1'b0;
  assign bus.busy      = w_busy;
  assign bus.img_done  = w_img_done;
endmodule
